// File: rtl/i2c_regbank_slave_if.sv
// i2c_regbank_slave_if
// Groups the bus clock and the register-side signals of the I2C register-bank
// slave. SDA is an open-drain inout and stays a plain port of the slave.
//   scl       : I2C clock from the bus master
//   rd_data   : NUM_REGS read bytes, byte i = rd_data[8i+7:8i]
//   wr_regs   : NUM_REGS write register bank
//   wr_strobe : one-clk pulse when a register is written
//   wr_index  : index of the register written, valid with wr_strobe
//   busy      : addressed transfer in progress
`timescale 1ns/1ps
interface i2c_regbank_slave_if #(
  parameter int NUM_REGS = 4
);
  localparam int PW = $clog2(NUM_REGS);

  logic                  scl;
  logic [NUM_REGS*8-1:0] rd_data;
  logic [NUM_REGS*8-1:0] wr_regs;
  logic                  wr_strobe;
  logic [PW-1:0]         wr_index;
  logic                  busy;

  modport slave (
    input  scl,
    input  rd_data,
    output wr_regs,
    output wr_strobe,
    output wr_index,
    output busy
  );

  modport master (
    output scl,
    output rd_data,
    input  wr_regs,
    input  wr_strobe,
    input  wr_index,
    input  busy
  );
endinterface

// File: rtl/i2c_regbank_slave.sv
// i2c_regbank_slave
// I2C slave with a register pointer. On a write, the first data byte loads the
// pointer and later bytes land in the write register bank with pointer
// auto-increment. On a read, bytes of rd_data are returned starting at the
// pointer, auto-incrementing until the master NACKs. The pointer persists
// across transactions.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   sda         : open-drain I2C data (driven only when the output enable is set)
//   debug_state : current FSM state encoding
//   bus         : scl, rd_data, wr_regs, wr_strobe, wr_index, busy
`timescale 1ns/1ps
module i2c_regbank_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h57,
  parameter int         NUM_REGS   = 4,
  parameter logic [7:0] RESET_VAL  = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  inout  wire                 sda,
  output logic [3:0]          debug_state,
  i2c_regbank_slave_if.slave  bus
);
  localparam int            PW      = $clog2(NUM_REGS);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_ADDR   = 4'd1,
    ADDR_ACK  = 4'd2,
    RX_PTR    = 4'd3,
    PTR_ACK   = 4'd4,
    RX_DATA   = 4'd5,
    DATA_ACK  = 4'd6,
    TX_DATA   = 4'd7,
    TX_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  state_t                state_r;
  logic [2:0]            scl_sync_r;
  logic [2:0]            sda_sync_r;
  logic [3:0]            bit_cnt_r;
  logic [6:0]            shift_r;
  logic [7:0]            tx_shift_r;
  logic                  rw_r;
  logic                  ack_phase_r;
  logic                  sda_oe_r;
  logic                  sda_o_r;
  logic                  busy_r;
  logic                  wr_strobe_r;
  logic [PW-1:0]         ptr_r;
  logic [PW-1:0]         wr_index_r;
  logic [NUM_REGS*8-1:0] wr_regs_r;

  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic       sda_bit_s;
  logic [7:0] rx_byte_s;
  logic [7:0] rd_byte_s;

  assign scl_rise_s = scl_sync_r[1] & ~scl_sync_r[2];
  assign scl_fall_s = ~scl_sync_r[1] & scl_sync_r[2];
  // SCL must be high in both compared stages so an SDA change right at an SCL
  // edge is never mistaken for START/STOP.
  assign start_s    = scl_sync_r[1] & scl_sync_r[2] & sda_sync_r[2] & ~sda_sync_r[1];
  assign stop_s     = scl_sync_r[1] & scl_sync_r[2] & ~sda_sync_r[2] & sda_sync_r[1];
  assign sda_bit_s  = sda_sync_r[1];
  // Byte completed by the bit arriving on this rising edge.
  assign rx_byte_s  = {shift_r, sda_bit_s};
  assign rd_byte_s  = bus.rd_data[{ptr_r, 3'b000} +: 8];

  assign sda           = sda_oe_r ? sda_o_r : 1'bz;
  assign debug_state   = state_r;
  assign bus.wr_regs   = wr_regs_r;
  assign bus.wr_strobe = wr_strobe_r;
  assign bus.wr_index  = wr_index_r;
  assign bus.busy      = busy_r;

  // Three-flop synchronisers for the asynchronous bus lines (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 3'b111;
      sda_sync_r <= 3'b111;
    end else begin
      scl_sync_r <= {scl_sync_r[1:0], bus.scl};
      sda_sync_r <= {sda_sync_r[1:0], sda};
    end
  end

  // Protocol FSM with all bus-facing and register-bank outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 7'd0;
      tx_shift_r  <= 8'd0;
      rw_r        <= 1'b0;
      ack_phase_r <= 1'b0;
      sda_oe_r    <= 1'b0;
      sda_o_r     <= 1'b1;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      ptr_r       <= '0;
      wr_index_r  <= '0;
      wr_regs_r   <= {NUM_REGS{RESET_VAL}};
    end else begin
      wr_strobe_r <= 1'b0;
      if (stop_s && (state_r != IDLE)) begin
        state_r     <= IDLE;
        sda_oe_r    <= 1'b0;
        busy_r      <= 1'b0;
        bit_cnt_r   <= 4'd0;
        ack_phase_r <= 1'b0;
      end else if (start_s) begin
        state_r     <= RX_ADDR;
        sda_oe_r    <= 1'b0;
        bit_cnt_r   <= 4'd0;
        ack_phase_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            sda_oe_r <= 1'b0;
          end
          RX_ADDR, RX_PTR, RX_DATA: begin
            if (scl_rise_s) begin
              shift_r <= rx_byte_s[6:0];
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r   <= 4'd0;
                ack_phase_r <= 1'b0;
                case (state_r)
                  RX_ADDR: begin
                    if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                      state_r <= ADDR_ACK;
                      busy_r  <= 1'b1;
                      rw_r    <= rx_byte_s[0];
                    end else begin
                      state_r <= WAIT_STOP;
                      busy_r  <= 1'b0;
                    end
                  end
                  RX_PTR: begin
                    ptr_r   <= rx_byte_s[PW-1:0];
                    state_r <= PTR_ACK;
                  end
                  default: begin
                    wr_regs_r[{ptr_r, 3'b000} +: 8] <= rx_byte_s;
                    wr_strobe_r <= 1'b1;
                    wr_index_r  <= ptr_r;
                    ptr_r       <= ptr_r + PTR_ONE;
                    state_r     <= DATA_ACK;
                  end
                endcase
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          ADDR_ACK, PTR_ACK, DATA_ACK: begin
            // First falling edge starts the ACK, the second one ends it.
            if (scl_fall_s) begin
              if (!ack_phase_r) begin
                sda_oe_r    <= 1'b1;
                sda_o_r     <= 1'b0;
                ack_phase_r <= 1'b1;
              end else begin
                ack_phase_r <= 1'b0;
                bit_cnt_r   <= 4'd0;
                if ((state_r == ADDR_ACK) && rw_r) begin
                  tx_shift_r <= {rd_byte_s[6:0], 1'b0};
                  sda_o_r    <= rd_byte_s[7];
                  sda_oe_r   <= 1'b1;
                  bit_cnt_r  <= 4'd1;
                  state_r    <= TX_DATA;
                end else if (state_r == ADDR_ACK) begin
                  sda_oe_r <= 1'b0;
                  state_r  <= RX_PTR;
                end else begin
                  sda_oe_r <= 1'b0;
                  state_r  <= RX_DATA;
                end
              end
            end
          end
          TX_DATA: begin
            // bit_cnt_r counts bits already placed on SDA.
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe_r    <= 1'b0;
                ack_phase_r <= 1'b0;
                state_r     <= TX_ACK;
              end else begin
                sda_o_r    <= tx_shift_r[7];
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                bit_cnt_r  <= bit_cnt_r + 4'd1;
              end
            end
          end
          TX_ACK: begin
            // ack_phase_r marks an ACK already seen; the next byte is loaded
            // with the incremented pointer on the following falling edge.
            if (scl_rise_s && !ack_phase_r) begin
              if (!sda_bit_s) begin
                ptr_r       <= ptr_r + PTR_ONE;
                ack_phase_r <= 1'b1;
              end else begin
                state_r <= WAIT_STOP;
              end
            end else if (scl_fall_s && ack_phase_r) begin
              tx_shift_r  <= {rd_byte_s[6:0], 1'b0};
              sda_o_r     <= rd_byte_s[7];
              sda_oe_r    <= 1'b1;
              bit_cnt_r   <= 4'd1;
              ack_phase_r <= 1'b0;
              state_r     <= TX_DATA;
            end
          end
          WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end
          default: begin
            sda_oe_r <= 1'b0;
            state_r  <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_regbank_slave.sv
// tb_i2c_regbank_slave
// Directed bench: a behavioural I2C master drives the slave through writes,
// combined write/read with wrap, pointer masking and persistence, address
// mismatch, a mid-byte rd_data change and a reset in the middle of a write.
`timescale 1ns/1ps
module tb_i2c_regbank_slave;
  localparam int NR = 4;
  localparam int Q  = 200;  // quarter of an SCL bit period, in ns

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sda_low = 1'b0;
  wire        sda;
  logic [3:0] debug_state;

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   strobe_cnt = 0;
  logic [1:0] strobe_idx [0:15];
  logic mon_en = 1'b0;
  logic drove  = 1'b0;

  i2c_regbank_slave_if #(.NUM_REGS(NR)) bus ();

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  i2c_regbank_slave #(
    .SLAVE_ADDR (7'h57),
    .NUM_REGS   (NR),
    .RESET_VAL  (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sda         (sda),
    .debug_state (debug_state),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Log write strobes and watch for the slave pulling SDA low when enabled.
  always @(posedge clk) begin
    if (bus.wr_strobe) begin
      strobe_idx[strobe_cnt[3:0]] <= bus.wr_index;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (!mon_en) drove <= 1'b0;
    else if (!sda_low && (sda == 1'b0)) drove <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    #Q sda_low = 1'b0;
    #Q bus.scl = 1'b1;
    #Q sda_low = 1'b1;
    #Q bus.scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_low = 1'b1;
    #Q bus.scl = 1'b1;
    #Q sda_low = 1'b0;
    #Q;
  endtask

  task automatic send_bit(input logic b);
    #Q sda_low = ~b;
    #Q bus.scl = 1'b1;
    #(2*Q) bus.scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    #Q sda_low = 1'b0;
    #Q bus.scl = 1'b1;
    #Q b = sda;
    #Q bus.scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  // chg_bit >= 0 replaces rd_data just before that bit of the byte is clocked.
  task automatic read_byte(input logic nack, input int chg_bit,
                           input logic [31:0] chg_val, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) bus.rd_data = chg_val;
      recv_bit(b);
      d = {d[6:0], b};
    end
    #Q sda_low = ~nack;
    #Q bus.scl = 1'b1;
    #(2*Q) bus.scl = 1'b0;
    #1 sda_low = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ack;
    logic [7:0]  d;
    logic [31:0] regs_save;
    int          cnt_save;

    bus.scl     = 1'b1;
    bus.rd_data = 32'h0000_0000;
    #103 rst_n  = 1'b1;
    #100;

    // Reset state
    check("rst_wr_regs", bus.wr_regs, 32'h0000_0000);
    check("rst_strobe", bus.wr_strobe, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_state", debug_state, 32'd0);
    check("rst_sda", sda, 32'd1);

    // Write pointer 1, then two data bytes
    i2c_start();
    write_byte(8'hAE, ack); check("wr_addr_ack", ack, 32'd1);
    check("wr_busy", bus.busy, 32'd1);
    write_byte(8'h01, ack); check("wr_ptr_ack", ack, 32'd1);
    write_byte(8'h5A, ack); check("wr_d0_ack", ack, 32'd1);
    write_byte(8'hC3, ack); check("wr_d1_ack", ack, 32'd1);
    i2c_stop();
    #Q;
    check("wr_regs", bus.wr_regs, 32'h00C3_5A00);
    check("wr_strobe_cnt", strobe_cnt, 32'd2);
    check("wr_idx0", strobe_idx[0], 32'd1);
    check("wr_idx1", strobe_idx[1], 32'd2);
    check("wr_busy_end", bus.busy, 32'd0);
    check("wr_state_end", debug_state, 32'd0);

    // Pointer upper bits ignored: 0x06 selects register 2
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'h06, ack); check("mask_ptr_ack", ack, 32'd1);
    write_byte(8'h7E, ack); check("mask_d_ack", ack, 32'd1);
    i2c_stop();
    #Q;
    check("mask_regs", bus.wr_regs, 32'h007E_5A00);
    check("mask_idx", strobe_idx[2], 32'd2);

    // Combined write pointer 3 / repeated START / read three bytes with wrap
    bus.rd_data = 32'h4433_2211;
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'h03, ack); check("cmb_ptr_ack", ack, 32'd1);
    i2c_start();
    write_byte(8'hAF, ack); check("cmb_raddr_ack", ack, 32'd1);
    read_byte(1'b0, -1, 32'h0, d); check("cmb_rd0", d, 32'h44);
    read_byte(1'b0, -1, 32'h0, d); check("cmb_rd1", d, 32'h11);
    read_byte(1'b1, -1, 32'h0, d); check("cmb_rd2", d, 32'h22);
    #Q;
    check("cmb_sda_released", sda, 32'd1);
    check("cmb_state_wait", debug_state, 32'd9);
    check("cmb_busy_wait", bus.busy, 32'd1);
    i2c_stop();
    #Q;
    check("cmb_state_idle", debug_state, 32'd0);
    check("cmb_busy_idle", bus.busy, 32'd0);

    // Pointer persists: read without pointer write continues at register 1
    i2c_start();
    write_byte(8'hAF, ack);
    read_byte(1'b1, -1, 32'h0, d); check("persist_rd", d, 32'h22);
    i2c_stop();

    // rd_data byte 0 changes mid-byte; the byte in flight is unaffected
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'h00, ack);
    i2c_stop();
    bus.rd_data = 32'h4433_2281;
    i2c_start();
    write_byte(8'hAF, ack);
    read_byte(1'b1, 3, 32'h4433_2200, d); check("snap_rd", d, 32'h81);
    i2c_stop();

    // Address mismatch: no ACK, SDA untouched, bank unchanged
    regs_save = bus.wr_regs;
    cnt_save  = strobe_cnt;
    mon_en    = 1'b1;
    i2c_start();
    write_byte(8'hB0, ack); check("mis_addr_nack", ack, 32'd0);
    check("mis_busy", bus.busy, 32'd0);
    write_byte(8'h12, ack); check("mis_data_nack", ack, 32'd0);
    i2c_stop();
    #Q;
    check("mis_sda_driven", drove, 32'd0);
    mon_en = 1'b0;
    check("mis_regs", bus.wr_regs, regs_save);
    check("mis_strobe_cnt", strobe_cnt, cnt_save);

    // Reset in the middle of a data byte
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("rst_mid_state", debug_state, 32'd5);
    sda_low = 1'b0;
    #20 rst_n = 1'b0;
    #20;
    check("rst_mid_regs", bus.wr_regs, 32'h0000_0000);
    check("rst_mid_sda", sda, 32'd1);
    check("rst_mid_busy", bus.busy, 32'd0);
    check("rst_mid_state_idle", debug_state, 32'd0);
    #20 rst_n = 1'b1;
    i2c_stop();

    // Pointer cleared by reset: read starts at register 0
    bus.rd_data = 32'h4433_2299;
    i2c_start();
    write_byte(8'hAF, ack); check("post_rst_ack", ack, 32'd1);
    read_byte(1'b1, -1, 32'h0, d); check("post_rst_rd", d, 32'h99);
    i2c_stop();
    #Q;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
